// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory data-port arbiter: arbitration state, read
// owner tag, request bundle and the return-pipeline entry.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CPU,
    ARB_DMA,
    ARB_DMA_LOCK
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  typedef struct packed {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // A byte-enable pattern of all zeros denotes a read access.
  function automatic logic is_read(input logic [3:0] wen);
    return wen == 4'b0000;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_return_pipe.sv
// Read-return tracker: a MEM_LAT-deep shift register of {valid, owner} tags,
// so returning read data can be steered to whoever issued the read.
module arb_rd_return_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  owner_t owner_i,
  output logic   valid_o,
  output owner_t owner_o
);

  rd_tag_t [MEM_LAT-1:0] pipe_q;

  // Shift one tag per cycle; a reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage is cleared, not just the head, so no stale valid
      // can surface after reset.
      pipe_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's
      // old value, which is what makes this a shift register.
      pipe_q[0] <= '{valid: push_i, owner: owner_i};
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[MEM_LAT-1].valid;
  assign owner_o = pipe_q[MEM_LAT-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared memory data port (port B) between the CPU data path
// and a DMA/loader master. One grant per cycle, CPU-first with DMA starvation
// protection and a bounded DMA burst lock. Read data returns MEM_LAT cycles
// after the grant and is steered to the owner recorded at grant time.
// Optional build macro ARB_PERF_CNT_EN adds CPU-stall and DMA-grant counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_hold,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic [3:0]  dma_wen,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
`ifdef ARB_PERF_CNT_EN
  input  logic        perf_clr,
  output logic [31:0] perf_cpu_stall,
  output logic [31:0] perf_dma_grant,
`endif
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam int unsigned SW = $clog2(MAX_WAIT + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_MAX_C = LW'(LOCK_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  logic     cpu_win, dma_win, lock_slot_due;
  mem_req_t cpu_acc, dma_acc, mem_sel;
  logic     rd_valid;
  owner_t   rd_owner;

  assign cpu_acc = '{wen: cpu_wen, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_acc = '{wen: dma_wen, addr: dma_addr, wdata: dma_wdata};

  // The CPU is owed one slot once a locked burst has used its full budget.
  assign lock_slot_due = (lock_cnt_q == LOCK_MAX_C) && cpu_req;

  // Priority grant: locked burst, starved DMA, CPU, then plain DMA.
  always_comb begin
    // NOTE: both grants default low before the priority chain so every path
    // assigns them and no latch is inferred.
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (state_q == ARB_DMA_LOCK && dma_req && !lock_slot_due) begin
      dma_win = 1'b1;
    end else if (dma_req && starve_cnt_q == MAX_WAIT_C) begin
      dma_win = 1'b1;
    end else if (cpu_req) begin
      cpu_win = 1'b1;
    end else if (dma_req) begin
      dma_win = 1'b1;
    end
  end

  // Route the winner's fields to the memory port; all zeros when idle.
  always_comb begin
    mem_sel = '0;
    if (cpu_win) begin
      mem_sel = cpu_acc;
    end else if (dma_win) begin
      mem_sel = dma_acc;
    end
  end

  assign mem_en   = cpu_win | dma_win;
  assign mem_wen  = mem_sel.wen;
  assign mem_addr = mem_sel.addr;
  assign mem_din  = mem_sel.wdata;
  assign cpu_hold = cpu_req & ~cpu_win;
  assign dma_gnt  = dma_win;

  // Next owner, starvation counter and lock budget.
  always_comb begin
    state_d      = ARB_IDLE;
    starve_cnt_d = starve_cnt_q;
    lock_cnt_d   = lock_cnt_q;

    if (dma_win) begin
      state_d = dma_lock ? ARB_DMA_LOCK : ARB_DMA;
    end else if (cpu_win) begin
      // A CPU grant while a locked burst still requests is the forced slot;
      // the burst keeps its lock state and resumes on the next cycle.
      state_d = (state_q == ARB_DMA_LOCK && dma_req) ? ARB_DMA_LOCK : ARB_CPU;
    end

    if (!dma_req || dma_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != MAX_WAIT_C) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    if (cpu_win) begin
      lock_cnt_d = '0;
    end else if (dma_win && dma_lock) begin
      if (lock_cnt_q != LOCK_MAX_C) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if (state_d != ARB_DMA_LOCK) begin
      lock_cnt_d = '0;
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  arb_rd_return_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_rd_return_pipe (
    .clk    (clk),
    .rst    (rst),
    .push_i (mem_en && is_read(mem_sel.wen)),
    .owner_i(dma_win ? OWN_DMA : OWN_CPU),
    .valid_o(rd_valid),
    .owner_o(rd_owner)
  );

  assign cpu_rvalid = rd_valid && (rd_owner == OWN_CPU);
  assign dma_rvalid = rd_valid && (rd_owner == OWN_DMA);
  assign cpu_rdata  = mem_dout;
  assign dma_rdata  = mem_dout;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_gnt_q;

  // Saturating event counters with a synchronous clear.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_stall_q <= '0;
      perf_gnt_q   <= '0;
    end else begin
      if (cpu_hold && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
      if (dma_win && perf_gnt_q != '1) begin
        perf_gnt_q <= perf_gnt_q + 1'b1;
      end
    end
  end

  assign perf_cpu_stall = perf_stall_q;
  assign perf_dma_grant = perf_gnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=2) share
// the same stimulus; expected read returns go into per-instance queues when a
// read grant is expected and are popped when the return is due.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int     due;
    owner_t own;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, dma_req, dma_lock;
  logic [3:0]  cpu_wen, dma_wen;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_dout;

  logic [1:0]  cpu_hold, cpu_rvalid, dma_gnt, dma_rvalid, mem_en;
  logic [31:0] cpu_rdata [2];
  logic [31:0] dma_rdata [2];
  logic [3:0]  mem_wen   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_din   [2];
`ifdef ARB_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] perf_cpu_stall [2];
  logic [31:0] perf_dma_grant [2];
`endif

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ret_t rq[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LAT(1), .MAX_WAIT(4), .LOCK_MAX(16)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold[0]), .cpu_rdata(cpu_rdata[0]), .cpu_rvalid(cpu_rvalid[0]),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_wen(dma_wen), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt[0]), .dma_rdata(dma_rdata[0]),
    .dma_rvalid(dma_rvalid[0]),
`ifdef ARB_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_cpu_stall(perf_cpu_stall[0]), .perf_dma_grant(perf_dma_grant[0]),
`endif
    .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
    .mem_dout(mem_dout)
  );

  mem_port_arbiter #(.MEM_LAT(2), .MAX_WAIT(4), .LOCK_MAX(16)) u_dut_lat2 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_hold(cpu_hold[1]), .cpu_rdata(cpu_rdata[1]), .cpu_rvalid(cpu_rvalid[1]),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_wen(dma_wen), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt[1]), .dma_rdata(dma_rdata[1]),
    .dma_rvalid(dma_rvalid[1]),
`ifdef ARB_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_cpu_stall(perf_cpu_stall[1]), .perf_dma_grant(perf_dma_grant[1]),
`endif
    .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
    .mem_dout(mem_dout)
  );

  task automatic set_cpu(input logic req, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic lock, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dma_req = req; dma_lock = lock; dma_wen = wen; dma_addr = addr; dma_wdata = wdata;
  endtask

  // Advance to just after the next rising edge; memory data tracks the cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_dout = {16'hD0D0, cyc[15:0]};
  endtask

  // Record an expected read return for the selected instances.
  task automatic push_rd(input owner_t o, input bit to_lat1, input bit to_lat2);
    if (to_lat1) rq[0].push_back('{due: cyc + 1, own: o});
    if (to_lat2) rq[1].push_back('{due: cyc + 2, own: o});
  endtask

  // Move to the falling edge and compare returned-read signals to the queues.
  task automatic sample();
    logic        exp_c, exp_d;
    logic [31:0] got_data;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_c = 1'b0;
      exp_d = 1'b0;
      if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
        if (rq[k][0].own == OWN_CPU) exp_c = 1'b1;
        else exp_d = 1'b1;
        void'(rq[k].pop_front());
      end
      vectors++;
      if (cpu_rvalid[k] !== exp_c || dma_rvalid[k] !== exp_d) begin
        miscompares++;
        $display("FAIL rvalid lat%0d cyc%0d: cpu/dma got %b/%b expected %b/%b",
                 k + 1, cyc, cpu_rvalid[k], dma_rvalid[k], exp_c, exp_d);
      end
      if (exp_c || exp_d) begin
        got_data = exp_c ? cpu_rdata[k] : dma_rdata[k];
        vectors++;
        if (got_data !== {16'hD0D0, cyc[15:0]}) begin
          miscompares++;
          $display("FAIL rdata lat%0d cyc%0d: got %h expected %h",
                   k + 1, cyc, got_data, {16'hD0D0, cyc[15:0]});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      sample();
      vectors++;
      if ({mem_en[0], cpu_hold[0], dma_gnt[0]} !== 3'b000 || mem_wen[0] !== 4'h0 ||
          mem_addr[0] !== 32'h0 || mem_din[0] !== 32'h0) begin
        miscompares++;
        $display("FAIL idle cyc%0d: en/hold/gnt %b%b%b wen %h addr %h din %h expected 000/0/0/0",
                 cyc, mem_en[0], cpu_hold[0], dma_gnt[0], mem_wen[0], mem_addr[0], mem_din[0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    mem_dout = 32'h0;
    repeat (3) next_cycle();
    rst = 1'b0;
    sample();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({cpu_hold[k], dma_gnt[k], mem_en[k]} !== 3'b000 || mem_wen[k] !== 4'h0) begin
        miscompares++;
        $display("FAIL reset lat%0d: hold/gnt/en %b%b%b wen %h expected 000/0",
                 k + 1, cpu_hold[k], dma_gnt[k], mem_en[k], mem_wen[k]);
      end
`ifdef ARB_PERF_CNT_EN
      vectors++;
      if (perf_cpu_stall[k] !== 32'h0 || perf_dma_grant[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_perf lat%0d: stall %0d grant %0d expected 0 0",
                 k + 1, perf_cpu_stall[k], perf_dma_grant[k]);
      end
`endif
    end
    next_cycle();
  endtask

  task automatic test_cpu_reads();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h0001_0000 + 32'(4 * i);
      set_cpu(1'b1, 4'h0, a, 32'h0);
      set_dma(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      sample();
      vectors++;
      if ({mem_en[0], cpu_hold[0], dma_gnt[0]} !== 3'b100 || mem_wen[0] !== 4'h0 ||
          mem_addr[0] !== a) begin
        miscompares++;
        $display("FAIL cpu_read %0d: en/hold/gnt %b%b%b wen %h addr %h expected 100/0/%h",
                 i, mem_en[0], cpu_hold[0], dma_gnt[0], mem_wen[0], mem_addr[0], a);
      end
      push_rd(OWN_CPU, 1'b1, 1'b1);
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_starvation();
    logic        exp_dma;
    logic [31:0] exp_addr, exp_din;
    for (int i = 0; i < 10; i++) begin
      set_cpu(1'b1, 4'h0, 32'h0001_0100, 32'h1111_1111);
      set_dma(1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'hA5A5_0000 + 32'(i));
      exp_dma  = (i % 5 == 4);
      exp_addr = exp_dma ? 32'h3000_0000 : 32'h0001_0100;
      exp_din  = exp_dma ? 32'hA5A5_0000 + 32'(i) : 32'h1111_1111;
      sample();
      vectors++;
      if ({mem_en[0], cpu_hold[0], dma_gnt[0]} !== {1'b1, exp_dma, exp_dma} ||
          mem_wen[0] !== (exp_dma ? 4'hF : 4'h0) || mem_addr[0] !== exp_addr ||
          mem_din[0] !== exp_din) begin
        miscompares++;
        $display("FAIL starve %0d: en/hold/gnt %b%b%b addr %h din %h expected 1%b%b/%h/%h",
                 i, mem_en[0], cpu_hold[0], dma_gnt[0], mem_addr[0], mem_din[0],
                 exp_dma, exp_dma, exp_addr, exp_din);
      end
      if (!exp_dma) push_rd(OWN_CPU, 1'b1, 1'b1);
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_lock_burst();
    int          ngnt = 0;
    logic        exp_dma;
    logic [31:0] exp_addr;
    // CPU wins until DMA starves in; then 16 locked grants, a forced CPU
    // slot, and the remaining 4 locked grants.
    for (int i = 0; i < 25; i++) begin
      set_cpu(1'b1, 4'h0, 32'h0001_0200, 32'h0);
      set_dma(1'b1, 1'b1, 4'hF, 32'h2000_0000 + 32'(4 * ngnt), 32'hB000_0000 + 32'(ngnt));
      exp_dma  = (i >= 4 && i < 20) || (i >= 21);
      exp_addr = exp_dma ? 32'h2000_0000 + 32'(4 * ngnt) : 32'h0001_0200;
      sample();
      vectors++;
      if ({mem_en[0], cpu_hold[0], dma_gnt[0]} !== {1'b1, exp_dma, exp_dma} ||
          mem_wen[0] !== (exp_dma ? 4'hF : 4'h0) || mem_addr[0] !== exp_addr) begin
        miscompares++;
        $display("FAIL lock_burst %0d: en/hold/gnt %b%b%b wen %h addr %h expected 1%b%b/%h/%h",
                 i, mem_en[0], cpu_hold[0], dma_gnt[0], mem_wen[0], mem_addr[0],
                 exp_dma, exp_dma, exp_dma ? 4'hF : 4'h0, exp_addr);
      end
      if (exp_dma) ngnt++;
      else push_rd(OWN_CPU, 1'b1, 1'b1);
      next_cycle();
    end
    set_dma(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    vectors++;
    if ({mem_en[0], cpu_hold[0], dma_gnt[0]} !== 3'b100) begin
      miscompares++;
      $display("FAIL lock_release: en/hold/gnt %b%b%b expected 100",
               mem_en[0], cpu_hold[0], dma_gnt[0]);
    end
    push_rd(OWN_CPU, 1'b1, 1'b1);
    next_cycle();
    idle(3);
  endtask

  task automatic test_interleave();
    logic exp_cpu;
    for (int i = 0; i < 8; i++) begin
      exp_cpu = (i % 2 == 0);
      set_cpu(exp_cpu, 4'h0, 32'h0001_0300 + 32'(4 * i), 32'h0);
      set_dma(!exp_cpu || i == 6, 1'b0, (i == 5) ? 4'h3 : 4'h0, 32'h2000_0100 + 32'(4 * i),
              32'hC0DE_0000);
      sample();
      vectors++;
      if ({mem_en[0], cpu_hold[0], dma_gnt[0]} !== {1'b1, 1'b0, !exp_cpu} ||
          mem_addr[0] !== (exp_cpu ? 32'h0001_0300 : 32'h2000_0100) + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL interleave %0d: en/hold/gnt %b%b%b addr %h expected 10%b",
                 i, mem_en[0], cpu_hold[0], dma_gnt[0], mem_addr[0], !exp_cpu);
      end
      if (exp_cpu) push_rd(OWN_CPU, 1'b1, 1'b1);
      else if (i != 5) push_rd(OWN_DMA, 1'b1, 1'b1);
      next_cycle();
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b1, 4'h0, 32'h2000_0400, 32'h0);
    sample();
    vectors++;
    if ({mem_en[0], dma_gnt[0]} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_grant: en/gnt %b%b expected 11", mem_en[0], dma_gnt[0]);
    end
    // The MEM_LAT=1 return lands before the reset edge; the MEM_LAT=2 one must not.
    push_rd(OWN_DMA, 1'b1, 1'b0);
    next_cycle();
    rst = 1'b1;
    set_cpu(1'b1, 4'h0, 32'h0001_0500, 32'h0);
    set_dma(1'b1, 1'b1, 4'h0, 32'h2000_0404, 32'h0);
    sample();
    next_cycle();
    rst = 1'b0;
    set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    vectors++;
    if ({cpu_hold[1], dma_gnt[1], mem_en[1]} !== 3'b000 || mem_wen[1] !== 4'h0 ||
        u_dut_lat2.state_q !== ARB_IDLE || u_dut_lat2.starve_cnt_q !== '0 ||
        u_dut_lat2.lock_cnt_q !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_state: hold/gnt/en %b%b%b state %0d starve %0d lock %0d expected 000/0/0/0",
               cpu_hold[1], dma_gnt[1], mem_en[1], u_dut_lat2.state_q,
               u_dut_lat2.starve_cnt_q, u_dut_lat2.lock_cnt_q);
    end
    next_cycle();
    idle(3);
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf_counters();
    perf_clr = 1'b1;
    set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b1, 4'hF, 32'h2000_0800, 32'h0);
    sample();
    next_cycle();
    perf_clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_cpu(1'b1, 4'h0, 32'h0001_0400, 32'h0);
      sample();
      vectors++;
      if (cpu_hold[0] !== 1'b1 || dma_gnt[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL perf_stall %0d: hold/gnt %b%b expected 11", i, cpu_hold[0], dma_gnt[0]);
      end
      next_cycle();
    end
    perf_clr = 1'b1;
    set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    vectors++;
    if (perf_cpu_stall[0] !== 32'd7 || perf_dma_grant[0] !== 32'd7) begin
      miscompares++;
      $display("FAIL perf_count: stall %0d grant %0d expected 7 7",
               perf_cpu_stall[0], perf_dma_grant[0]);
    end
    next_cycle();
    perf_clr = 1'b0;
    sample();
    vectors++;
    if (perf_cpu_stall[0] !== 32'd0 || perf_dma_grant[0] !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_clear: stall %0d grant %0d expected 0 0",
               perf_cpu_stall[0], perf_dma_grant[0]);
    end
    next_cycle();
    idle(2);
  endtask
`endif

  initial begin
`ifdef ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    test_reset();
    test_cpu_reads();
    test_starvation();
    test_lock_burst();
    test_interleave();
    test_reset_midflight();
`ifdef ARB_PERF_CNT_EN
    test_perf_counters();
`endif
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (rq[k].size() != 0) begin
        miscompares++;
        $display("FAIL drain lat%0d: %0d returns outstanding expected 0", k + 1, rq[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
